decryption_module: RTL
======================

# decryption_module

Decrypts the 5-bit cypher stream produced by the encryption stage back into plaintext letters and assembles them into a four-letter word for display. It sits directly downstream of the encryption stage, consuming its `cypher_text`, `cypher_key` and `enable_next` outputs on the same clock. It tracks the same four-letter-plus-restart sequence as the encryption stage, so both stages stay aligned on letter slots.

## Interface
- `LETTER_MAX`, default 26: largest valid letter and key value. The modulus is `LETTER_MAX+1`.
- `clk` input 1: system clock; all logic is rising-edge.
- `rst` input 1: reset, synchronous, active-low.
- `enable_in` input 1: event strobe, driven from the encryption stage's `enable_next`. It is sampled every cycle (level, not edge).
- `cypher_text` input 5: encrypted letter, valid in any cycle where `enable_in`=1.
- `cypher_key` input 5: key used for that letter, valid with `cypher_text`.
- `plain_text` output 5: most recently decrypted letter.
- `plain_word` output 20: letters packed as [4:0]=slot 0 … [19:15]=slot 3.
- `char_valid` output 4: bit n is set once slot n holds a letter.
- `word_done` output 1: high while all four slots are valid.
- `key_err` output 1: sticky range-error flag. It is 0 when the `DECRYPT_KEY_CHECK_EN` feature is compiled out.

## Operation
- States and transitions:
  - `S_L1`, `S_L2`, `S_L3`, `S_L4`: each waits for an event (`enable_in`=1 in a cycle). On the event, the block decrypts into the current slot and advances: L1→L2→L3→L4→`S_FULL`.
  - `S_FULL`: an event clears `plain_word`, `char_valid`, `word_done` and `plain_text` to 0 and goes to `S_L1`. No decrypt and no capture happen on this event; this mirrors the upstream restart event, which carries no new letter.
  - With no event, the state and all outputs hold.
- Decryption, with c=`cypher_text` and k=`cypher_key`:
  - If c ≥ k: p = c − k.
  - Otherwise: p = c + (`LETTER_MAX`+1) − k. Use a 6-bit intermediate and truncate the result to 5 bits.
  - This exactly inverts the upstream rule c = (p + k) mod 27 for p, k in 0..26.
- On a capturing event, in a single cycle:
  - `plain_text` ← p
  - slot[n] ← p
  - `char_valid[n]` ← 1
  - For slot 3, `word_done` ← 1 on the same edge.
- Out-of-range inputs (c > 26 or k > 26) are still decrypted by the same formula. The result is unspecified-but-deterministic, truncated to 5 bits.

## Timing
- Reset: all outputs 0, state `S_L1`. Reset takes priority over a simultaneous event.
- Reset mid-word discards all captured slots.
- Latency: event on edge N, outputs updated at edge N+1, which is one registered stage. There is no combinational path from input to output.
- Back-to-back events, one per cycle, are each consumed. Holding `enable_in` high for 5 cycles from `S_L1` fills all four slots and then clears on the fifth cycle.
- `word_done` rises on the same edge as `char_valid`=4'b1111. It falls on the restart event or on reset.

## Configuration
- Macro: `DECRYPT_KEY_CHECK_EN`.
- Defined:
  - On any capturing event with `cypher_text` > `LETTER_MAX` or `cypher_key` > `LETTER_MAX`, `key_err` is set on the following edge.
  - `key_err` stays set until reset. The restart event does not clear it.
  - Decryption proceeds unchanged.
- Undefined: no comparators are built and `key_err` is constant 0.

## Test plan
- **Reset:** rst=0 for 2 cycles with `enable_in`=1 → all outputs 0, state `S_L1`, no capture.
- **No-wrap:** event with c=8, k=5 → `plain_text`=3, slot 0=3, `char_valid`=4'b0001 one cycle later.
- **Wrap:** event with c=3, k=10 → `plain_text`=20. Also c=0, k=26 → 1.
- **Full word and restart:** four single-cycle events decrypting to 8, 5, 12, 16 → `plain_word`={16,12,5,8}, `word_done`=1. The fifth event → all outputs 0, state `S_L1`, and the 5th c/k are ignored.
- **Held enable and mid-word reset:** `enable_in` held 3 cycles → `char_valid`=4'b0111. Then rst=0 → all outputs 0. The next event lands in slot 0.
- **`DECRYPT_KEY_CHECK_EN`:** event with k=30 → `key_err`=1 next cycle and held through a restart. With the macro undefined, the same stimulus gives `key_err`=0.

Source files
------------

// File: rtl/decryption_module.sv
// Decrypts the 5-bit cypher stream and assembles four letters into a display word.
// Optional sticky range check on cypher_text/cypher_key: define DECRYPT_KEY_CHECK_EN.
module decryption_module #(
   parameter int unsigned LETTER_MAX = 26
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable_in,
   input  logic [4:0]  cypher_text,
   input  logic [4:0]  cypher_key,
   output logic [4:0]  plain_text,
   output logic [19:0] plain_word,
   output logic [3:0]  char_valid,
   output logic        word_done,
   output logic        key_err
);

   localparam logic [5:0] LetterMax6 = 6'(LETTER_MAX);
   localparam logic [5:0] Modulus6   = LetterMax6 + 6'd1;

   typedef enum logic [2:0] {S_L1, S_L2, S_L3, S_L4, S_FULL} state_t;

   state_t     state_q;
   logic [5:0] c6;
   logic [5:0] k6;
   logic [5:0] p6;
   logic [4:0] p;

   assign c6 = {1'b0, cypher_text};
   assign k6 = {1'b0, cypher_key};

   // Borrow case adds the modulus back; 6 bits hold c + 27 without overflow.
   always_comb begin
      p6 = 6'd0;
      if (c6 >= k6) begin
         p6 = c6 - k6;
      end else begin
         p6 = c6 + Modulus6 - k6;
      end
   end
   assign p = p6[4:0];

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= S_L1;
         plain_text <= 5'd0;
         plain_word <= 20'd0;
         char_valid <= 4'd0;
         word_done  <= 1'b0;
      end else if (enable_in) begin
         unique case (state_q)
            S_L1: begin
               plain_text      <= p;
               plain_word[4:0] <= p;
               char_valid[0]   <= 1'b1;
               state_q         <= S_L2;
            end
            S_L2: begin
               plain_text      <= p;
               plain_word[9:5] <= p;
               char_valid[1]   <= 1'b1;
               state_q         <= S_L3;
            end
            S_L3: begin
               plain_text        <= p;
               plain_word[14:10] <= p;
               char_valid[2]     <= 1'b1;
               state_q           <= S_L4;
            end
            S_L4: begin
               plain_text        <= p;
               plain_word[19:15] <= p;
               char_valid[3]     <= 1'b1;
               word_done         <= 1'b1;
               state_q           <= S_FULL;
            end
            S_FULL: begin
               // Restart event carries no letter: clear only.
               plain_text <= 5'd0;
               plain_word <= 20'd0;
               char_valid <= 4'd0;
               word_done  <= 1'b0;
               state_q    <= S_L1;
            end
            default: state_q <= S_L1;
         endcase
      end
   end

`ifdef DECRYPT_KEY_CHECK_EN
   logic key_err_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         key_err_q <= 1'b0;
      end else if (enable_in && (state_q != S_FULL) &&
                   ((c6 > LetterMax6) || (k6 > LetterMax6))) begin
         key_err_q <= 1'b1;
      end
   end

   assign key_err = key_err_q;
`else
   assign key_err = 1'b0;
`endif

endmodule
